// File: rtl/geofence_sort_area_ctrl.sv
// ---------------------------------------------------------------------------
// geofence_sort_area_ctrl
//   Sequencer for the geofence polygon datapath. It loads NPTS points
//   (X, Y, R). Point 0 is the anchor. Points 1..NPTS-1 are ordered clockwise
//   around the anchor using bubble passes on one shared cross-product unit.
//   The same two multipliers then accumulate the shoelace sum. Finally the
//   sorted points, together with |2*area|, are streamed downstream under
//   valid/ready.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   point load handshake; X, Y (CW bits), R (RW bits)
//   out_valid/out_ready sorted point stream handshake
//   out_idx             index of the beat currently presented (0..NPTS-1)
//   out_x/out_y/out_r   sorted point; R travels with its point
//   out_last            high on beat NPTS-1
//   area2               |shoelace sum|; holds until the next area pass ends
// ---------------------------------------------------------------------------
module geofence_sort_area_ctrl #(
   parameter int NPTS = 6,
   parameter int CW   = 10,
   parameter int RW   = 11
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CW-1:0]   X,
   input  logic [CW-1:0]   Y,
   input  logic [RW-1:0]   R,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2:0]      out_idx,
   output logic [CW-1:0]   out_x,
   output logic [CW-1:0]   out_y,
   output logic [RW-1:0]   out_r,
   output logic            out_last,
   output logic [2*CW:0]   area2
);

   localparam int IW = $clog2(NPTS);
   // Multiplier and accumulator width. It covers signed vector differences
   // and the full shoelace sum without overflow.
   localparam int PW = 2*CW+4;
   localparam logic [IW-1:0] LAST = IW'(NPTS-1);
   localparam logic [IW-1:0] PEND = IW'(NPTS-2);   // last compare index of a pass

   typedef enum logic [1:0] {S_LOAD, S_SORT, S_AREA, S_OUT} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        cnt_q, cnt_d;      // load slot / compare i / area k / out j
   logic                 swf_q, swf_d;      // a swap happened in this pass
   logic signed [PW-1:0] acc_q, acc_d;
   logic [2*CW:0]        area2_q, area2_d;
   logic [CW-1:0]        px_q [NPTS];
   logic [CW-1:0]        px_d [NPTS];
   logic [CW-1:0]        py_q [NPTS];
   logic [CW-1:0]        py_d [NPTS];
   logic [RW-1:0]        pr_q [NPTS];
   logic [RW-1:0]        pr_d [NPTS];

   function automatic logic signed [PW-1:0] zx(input logic [CW-1:0] v);
      return $signed({{(PW-CW){1'b0}}, v});
   endfunction

   // Operand fetch. nxt wraps only during the area pass.
   logic [IW-1:0] nxt;
   logic [CW-1:0] xi, yi, xn, yn;
   logic [RW-1:0] ri, rn;

   assign nxt = (cnt_q == LAST) ? '0 : cnt_q + IW'(1);
   assign xi  = px_q[cnt_q];
   assign yi  = py_q[cnt_q];
   assign ri  = pr_q[cnt_q];
   assign xn  = px_q[nxt];
   assign yn  = py_q[nxt];
   assign rn  = pr_q[nxt];

   // Shared cross-product unit.
   //   SORT: vectors taken relative to the anchor.
   //   AREA: raw coordinates, zero-extended.
   logic signed [PW-1:0] a1, b1, a2, b2, term, acc_sum, acc_abs;
   logic                 cross_pos;

   always_comb begin
      if (state_q == S_SORT) begin
         a1 = zx(xi) - zx(px_q[0]);
         b1 = zx(yn) - zx(py_q[0]);
         a2 = zx(xn) - zx(px_q[0]);
         b2 = zx(yi) - zx(py_q[0]);
      end else begin
         a1 = zx(xi);
         b1 = zx(yn);
         a2 = zx(xn);
         b2 = zx(yi);
      end
   end

   assign term      = a1 * b1 - a2 * b2;
   assign cross_pos = (state_q == S_SORT) && !term[PW-1] && (term != '0);
   assign acc_sum   = acc_q + term;
   assign acc_abs   = acc_sum[PW-1] ? -acc_sum : acc_sum;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      swf_d   = swf_q;
      acc_d   = acc_q;
      area2_d = area2_q;
      px_d    = px_q;
      py_d    = py_q;
      pr_d    = pr_q;
      case (state_q)
         S_LOAD: begin
            if (in_valid) begin
               px_d[cnt_q] = X;
               py_d[cnt_q] = Y;
               pr_d[cnt_q] = R;
               if (cnt_q == LAST) begin
                  state_d = S_SORT;
                  cnt_d   = IW'(1);
                  swf_d   = 1'b0;
               end else begin
                  cnt_d = cnt_q + IW'(1);
               end
            end
         end
         S_SORT: begin
            if (cross_pos) begin
               px_d[cnt_q] = xn;
               py_d[cnt_q] = yn;
               pr_d[cnt_q] = rn;
               px_d[nxt]   = xi;
               py_d[nxt]   = yi;
               pr_d[nxt]   = ri;
            end
            if (cnt_q == PEND) begin
               // A swap on this final compare also forces another pass.
               if (swf_q || cross_pos) begin
                  swf_d = 1'b0;
                  cnt_d = IW'(1);
               end else begin
                  state_d = S_AREA;
                  cnt_d   = '0;
                  acc_d   = '0;
               end
            end else begin
               swf_d = swf_q | cross_pos;
               cnt_d = cnt_q + IW'(1);
            end
         end
         S_AREA: begin
            acc_d = acc_sum;
            if (cnt_q == LAST) begin
               area2_d = acc_abs[2*CW:0];
               state_d = S_OUT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + IW'(1);
            end
         end
         default: begin   // S_OUT
            if (out_ready) begin
               if (cnt_q == LAST) begin
                  state_d = S_LOAD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + IW'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_LOAD;
         cnt_q   <= '0;
         swf_q   <= 1'b0;
         acc_q   <= '0;
         area2_q <= '0;
         for (int n = 0; n < NPTS; n++) begin
            px_q[n] <= '0;
            py_q[n] <= '0;
            pr_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         swf_q   <= swf_d;
         acc_q   <= acc_d;
         area2_q <= area2_d;
         px_q    <= px_d;
         py_q    <= py_d;
         pr_q    <= pr_d;
      end
   end

   assign in_ready  = (state_q == S_LOAD);
   assign out_valid = (state_q == S_OUT);
   assign out_idx   = out_valid ? 3'(cnt_q) : 3'd0;
   assign out_x     = out_valid ? xi : '0;
   assign out_y     = out_valid ? yi : '0;
   assign out_r     = out_valid ? ri : '0;
   assign out_last  = out_valid && (cnt_q == LAST);
   assign area2     = area2_q;

endmodule

// File: tb/tb_geofence_sort_area_ctrl.sv
// ---------------------------------------------------------------------------
// tb_geofence_sort_area_ctrl
//   Directed bench for geofence_sort_area_ctrl. A behavioural model computes
//   the clockwise order, the number of sort passes and |2*area| from each
//   point set. A negedge compare process checks every output beat against
//   that model. Literal values pin the model for the hand-worked cases.
// ---------------------------------------------------------------------------
module tb_geofence_sort_area_ctrl;
   localparam int NPTS = 6;
   localparam int CW   = 10;
   localparam int RW   = 11;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [CW-1:0]   X, Y;
   logic [RW-1:0]   R;
   logic            out_valid;
   logic            out_ready;
   logic [2:0]      out_idx;
   logic [CW-1:0]   out_x, out_y;
   logic [RW-1:0]   out_r;
   logic            out_last;
   logic [2*CW:0]   area2;

   always #5 clk = ~clk;

   geofence_sort_area_ctrl #(.NPTS(NPTS), .CW(CW), .RW(RW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .X(X), .Y(Y), .R(R),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_x(out_x), .out_y(out_y), .out_r(out_r),
      .out_last(out_last), .area2(area2)
   );

   int     n_chk = 0;
   int     n_fail = 0;
   int     in_x [NPTS];
   int     in_y [NPTS];
   int     in_r [NPTS];
   int     ex_x [NPTS];
   int     ex_y [NPTS];
   int     ex_r [NPTS];
   longint ex_area;
   int     ex_sort;
   int     exp_j = 0;
   bit     exp_ok = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_pt(input int k, input int x, input int y, input int r);
      in_x[k] = x; in_y[k] = y; in_r[k] = r;
   endtask

   // Clockwise ordering about the anchor. Points are swapped while the
   // later point lies counter-clockwise of the earlier one.
   task automatic model();
      int     passes;
      bit     sw;
      longint c, a;
      int     t, kn;
      for (int k = 0; k < NPTS; k++) begin
         ex_x[k] = in_x[k]; ex_y[k] = in_y[k]; ex_r[k] = in_r[k];
      end
      passes = 0;
      do begin
         sw = 0;
         passes++;
         for (int i = 1; i <= NPTS-2; i++) begin
            c = longint'(ex_x[i]-ex_x[0]) * longint'(ex_y[i+1]-ex_y[0])
              - longint'(ex_x[i+1]-ex_x[0]) * longint'(ex_y[i]-ex_y[0]);
            if (c > 0) begin
               t = ex_x[i]; ex_x[i] = ex_x[i+1]; ex_x[i+1] = t;
               t = ex_y[i]; ex_y[i] = ex_y[i+1]; ex_y[i+1] = t;
               t = ex_r[i]; ex_r[i] = ex_r[i+1]; ex_r[i+1] = t;
               sw = 1;
            end
         end
      end while (sw);
      ex_sort = passes * (NPTS-2);
      a = 0;
      for (int k = 0; k < NPTS; k++) begin
         kn = (k + 1) % NPTS;
         a += longint'(ex_x[k]) * ex_y[kn] - longint'(ex_x[kn]) * ex_y[k];
      end
      ex_area = (a < 0) ? -a : a;
   endtask

   // Drives NPTS beats back to back with in_valid held high.
   task automatic load_pts();
      for (int k = 0; k < NPTS; k++) begin
         in_valid = 1'b1;
         X = CW'(in_x[k]); Y = CW'(in_y[k]); R = RW'(in_r[k]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // One full load/sort/area/stream transaction. mode 1 applies backpressure:
   // five stall cycles on beat 2, then out_ready toggles every cycle.
   task automatic run_case(input string tag, input int mode, input bit glitch,
                           output int sort_cyc);
      int c, c2, stall;
      bit tog;
      model();
      exp_j  = 0;
      exp_ok = 1;
      out_ready = 1'b1;
      load_pts();
      c = 0;
      while (!out_valid && c < 300) begin
         if (glitch && c < 3) begin
            in_valid = 1'b1;
            X = CW'($urandom_range(0, 1023));
            Y = CW'($urandom_range(0, 1023));
            R = RW'($urandom_range(0, 2047));
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         c++;
      end
      in_valid = 1'b0;
      chk({tag, "_reached_out"}, out_valid, 1);
      sort_cyc = c - NPTS;
      chk({tag, "_sort_cycles"}, sort_cyc, ex_sort);
      stall = 0; tog = 0; c2 = 0;
      while (out_valid && c2 < 100) begin
         if (mode == 0) out_ready = 1'b1;
         else if (stall < 5 && out_idx == 3'd2) begin
            out_ready = 1'b0; stall++;
         end else if (stall >= 5) begin
            out_ready = tog; tog = !tog;
         end else out_ready = 1'b1;
         @(posedge clk); #1;
         c2++;
      end
      out_ready = 1'b1;
      chk({tag, "_beats_seen"}, exp_j, NPTS);
      chk({tag, "_in_ready_after"}, in_ready, 1);
      chk({tag, "_out_valid_after"}, out_valid, 0);
      chk({tag, "_area2_held"}, area2, ex_area);
      exp_ok = 0;
   endtask

   // Per-cycle output compare against the model's expected stream.
   always @(negedge clk) begin
      if (reset) begin
         if (out_valid) begin
            if (!exp_ok || exp_j >= NPTS) chk("unexpected_beat", 1, 0);
            else begin
               chk("out_idx",  out_idx,  exp_j);
               chk("out_x",    out_x,    ex_x[exp_j]);
               chk("out_y",    out_y,    ex_y[exp_j]);
               chk("out_r",    out_r,    ex_r[exp_j]);
               chk("out_last", out_last, (exp_j == NPTS-1) ? 1 : 0);
               if (out_last) chk("area2", area2, ex_area);
               if (out_ready) exp_j++;
            end
         end else begin
            chk("out_last_idle", out_last, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   task automatic hex_rev();
      set_pt(0, 10, 0, 100); set_pt(1, 20, 0, 101); set_pt(2, 25, 10, 102);
      set_pt(3, 20, 20, 103); set_pt(4, 10, 20, 104); set_pt(5, 5, 10, 105);
   endtask

   task automatic corners();
      set_pt(0, 0, 0, 2047); set_pt(1, 1023, 0, 1); set_pt(2, 1023, 512, 2);
      set_pt(3, 1023, 1023, 3); set_pt(4, 512, 1023, 4); set_pt(5, 0, 1023, 5);
   endtask

   initial begin
      int sc;
      reset = 1'b0; in_valid = 1'b0; X = '0; Y = '0; R = '0; out_ready = 1'b1;
      #2;
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last",  out_last,  0);
      chk("rst_out_idx",   out_idx,   0);
      chk("rst_area2",     area2,     0);
      chk("rst_out_x",     out_x,     0);
      chk("rst_out_y",     out_y,     0);
      chk("rst_out_r",     out_r,     0);
      #10 reset = 1'b1;
      @(posedge clk); #1;

      // 1: counter-clockwise hexagon -> full reversal
      hex_rev();
      run_case("hex_rev", 0, 0, sc);
      chk("hex_rev_lit_sort", sc, 20);
      chk("hex_rev_lit_area", ex_area, 600);
      chk("hex_rev_lit_p1x", ex_x[1], 5);
      chk("hex_rev_lit_p1y", ex_y[1], 10);
      chk("hex_rev_lit_p1r", ex_r[1], 105);
      chk("hex_rev_lit_p5x", ex_x[5], 20);
      chk("hex_rev_lit_p5y", ex_y[5], 0);

      // 2: already clockwise -> single pass
      set_pt(0, 10, 0, 7); set_pt(1, 5, 10, 8); set_pt(2, 10, 20, 9);
      set_pt(3, 20, 20, 10); set_pt(4, 25, 10, 11); set_pt(5, 20, 0, 12);
      run_case("hex_cw", 0, 0, sc);
      chk("hex_cw_lit_sort", sc, 4);
      chk("hex_cw_lit_area", ex_area, 600);

      // 3: full-range corners
      corners();
      run_case("corners", 0, 0, sc);
      chk("corners_lit_area", ex_area, 2093058);
      chk("corners_lit_p1x", ex_x[1], 0);
      chk("corners_lit_p1y", ex_y[1], 1023);
      chk("corners_lit_p4y", ex_y[4], 512);

      // 4: backpressure on the stream
      hex_rev();
      run_case("bp", 1, 0, sc);

      // 5: collinear points keep their input order
      set_pt(0, 0, 0, 1); set_pt(1, 0, 30, 2); set_pt(2, 30, 30, 3);
      set_pt(3, 10, 0, 4); set_pt(4, 20, 0, 5); set_pt(5, 30, 0, 6);
      run_case("colin", 0, 0, sc);
      chk("colin_lit_sort", sc, 4);
      chk("colin_lit_area", ex_area, 1200);
      chk("colin_lit_p3x", ex_x[3], 10);
      chk("colin_lit_p5x", ex_x[5], 30);

      // 6a: in_valid glitches during SORT are ignored
      hex_rev();
      run_case("glitch", 0, 1, sc);

      // 6b: reset mid-SORT, then a clean reload
      hex_rev();
      load_pts();
      for (int g = 0; g < 3; g++) begin
         in_valid = 1'b1; X = CW'(g * 77); Y = CW'(g * 31); R = RW'(g);
         @(posedge clk); #1;
      end
      chk("midsort_in_ready", in_ready, 0);
      #2 reset = 1'b0;
      #1;
      chk("abort_in_ready",  in_ready,  1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_area2",     area2,     0);
      chk("abort_out_idx",   out_idx,   0);
      in_valid = 1'b0;
      @(posedge clk); #3 reset = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_in_ready", in_ready, 1);
      corners();
      run_case("after_reset", 0, 0, sc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
